// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states,
// scancode prefix bytes and the parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL = 8'hF0;

    // PS/2 frames carry odd parity: data bits plus parity bit hold an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a level filter: the output follows the
// synchronized line only after FILTER_LEN consecutive cycles at the new level.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic             meta_q;
    logic             sync_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every variable gets a default first so no path through this block infers a latch.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            meta_q  <= line_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: filters both lines, deframes 11-bit frames and
// folds E0/F0 prefixes into flags delivered alongside the final scancode.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 48000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbd_clk,
    input  logic       kbd_data,
    output logic [7:0] kbd_key,
    output logic       kbd_key_valid,
    output logic       kbd_extended,
    output logic       kbd_released,
    output logic       frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic clk_f;
    logic data_f;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .rst     (rst),
        .line_i  (kbd_clk),
        .level_o (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .rst     (rst),
        .line_i  (kbd_data),
        .level_o (data_f)
    );

    ps2_state_e       state_q,    state_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [7:0]       shift_q,    shift_d;
    logic             par_ok_q,   par_ok_d;
    logic [TMO_W-1:0] tmo_q,      tmo_d;
    logic             ext_pend_q, ext_pend_d;
    logic             rel_pend_q, rel_pend_d;
    logic [7:0]       key_q,      key_d;
    logic             ext_q,      ext_d;
    logic             rel_q,      rel_d;
    logic             valid_q,    valid_d;
    logic             err_q,      err_d;
    logic             clk_prev_q;

    logic sample;
    logic timeout;

    assign sample  = clk_prev_q & ~clk_f;
    assign timeout = (state_q != ST_IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        tmo_d      = '0;
        ext_pend_d = ext_pend_q;
        rel_pend_d = rel_pend_q;
        key_d      = key_q;
        ext_d      = ext_q;
        rel_d      = rel_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        if (state_q != ST_IDLE && !sample) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        // A stalled frame wins over a coincident sample event.
        if (timeout) begin
            state_d    = ST_IDLE;
            tmo_d      = '0;
            err_d      = 1'b1;
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
        end else if (sample) begin
            case (state_q)
                ST_IDLE: begin
                    if (!data_f) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d = {data_f, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_ok_d = odd_parity_ok(shift_q, data_f);
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (data_f && par_ok_q) begin
                        if (shift_q == PS2_PFX_EXT) begin
                            ext_pend_d = 1'b1;
                        end else if (shift_q == PS2_PFX_REL) begin
                            rel_pend_d = 1'b1;
                        end else begin
                            key_d      = shift_q;
                            ext_d      = ext_pend_q;
                            rel_d      = rel_pend_q;
                            valid_d    = 1'b1;
                            ext_pend_d = 1'b0;
                            rel_pend_d = 1'b0;
                        end
                    end else begin
                        err_d      = 1'b1;
                        ext_pend_d = 1'b0;
                        rel_pend_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_ok_q   <= 1'b0;
            tmo_q      <= '0;
            ext_pend_q <= 1'b0;
            rel_pend_q <= 1'b0;
            key_q      <= '0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_ok_q   <= par_ok_d;
            tmo_q      <= tmo_d;
            ext_pend_q <= ext_pend_d;
            rel_pend_q <= rel_pend_d;
            key_q      <= key_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            clk_prev_q <= clk_f;
        end
    end

    assign kbd_key       = key_q;
    assign kbd_key_valid = valid_q;
    assign kbd_extended  = ext_q;
    assign kbd_released  = rel_q;
    assign frame_err     = err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: directed PS/2 frames push expected strobes,
// a negedge monitor pops and compares every strobe the receiver presents.
module tb_ps2_kbd_rx;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 200;
    localparam int HALF        = 40;
    // Raw fall -> strobe: 2-flop sync, FILTER_LEN filter cycles, edge detect, output register.
    localparam int LAT         = FILTER_LEN + 3;

    typedef struct {
        bit         is_err;
        logic [7:0] key;
        bit         ext;
        bit         rel;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       kbd_clk;
    logic       kbd_data;
    logic [7:0] kbd_key;
    logic       kbd_key_valid;
    logic       kbd_extended;
    logic       kbd_released;
    logic       frame_err;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    exp_t        sb[$];
    exp_t        exp_next;
    bit          exp_armed  = 1'b0;
    int          exp_delay  = 0;
    logic [10:0] glitch_mask = '0;

    ps2_kbd_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .kbd_clk       (kbd_clk),
        .kbd_data      (kbd_data),
        .kbd_key       (kbd_key),
        .kbd_key_valid (kbd_key_valid),
        .kbd_extended  (kbd_extended),
        .kbd_released  (kbd_released),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (kbd_key_valid || frame_err)) begin
            check("valid_err_exclusive", 32'(kbd_key_valid & frame_err), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: valid=%0b err=%0b key=%0h, none expected (cycle %0d)",
                         kbd_key_valid, frame_err, kbd_key, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_kind_err", 32'(frame_err), 32'(e.is_err));
                check("strobe_cycle", 32'(cyc), 32'(e.cyc));
                if (!e.is_err) begin
                    check("key", 32'(kbd_key), 32'(e.key));
                    check("extended", 32'(kbd_extended), 32'(e.ext));
                    check("released", 32'(kbd_released), 32'(e.rel));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Drives n bits of a frame; the armed expectation is pushed at the last falling edge.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            kbd_data = bits[i];
            if (glitch_mask[i]) begin
                repeat (15) @(negedge clk);
                kbd_clk = 1'b0;
                repeat (3) @(negedge clk);
                kbd_clk = 1'b1;
                repeat (HALF - 18) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            kbd_clk = 1'b0;
            if (i == n - 1 && exp_armed) begin
                exp_t e;
                e     = exp_next;
                e.cyc = cyc + exp_delay;
                sb.push_back(e);
                exp_armed = 1'b0;
            end
            repeat (HALF) @(negedge clk);
            kbd_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic expect_key(input logic [7:0] k, input bit ext, input bit rel);
        exp_next  = '{is_err: 1'b0, key: k, ext: ext, rel: rel, cyc: 0};
        exp_delay = LAT;
        exp_armed = 1'b1;
    endtask

    task automatic expect_err(input int delay);
        exp_next  = '{is_err: 1'b1, key: 8'h00, ext: 1'b0, rel: 1'b0, cyc: 0};
        exp_delay = delay;
        exp_armed = 1'b1;
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_key"}, 32'(kbd_key), 32'h00);
        check({tag, "_valid"}, 32'(kbd_key_valid), 32'd0);
        check({tag, "_ext"}, 32'(kbd_extended), 32'd0);
        check({tag, "_rel"}, 32'(kbd_released), 32'd0);
        check({tag, "_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        kbd_clk  = 1'b1;
        kbd_data = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_outputs_reset("reset");
        repeat (20) @(negedge clk);

        // Plain make code.
        expect_key(8'h1C, 1'b0, 1'b0);
        send_bits(frame(8'h1C, 1'b0), 11);

        // Break code.
        send_bits(frame(8'hF0, 1'b0), 11);
        expect_key(8'h1C, 1'b0, 1'b1);
        send_bits(frame(8'h1C, 1'b0), 11);

        // Extended break code, then flags must be clear again.
        send_bits(frame(8'hE0, 1'b0), 11);
        send_bits(frame(8'hF0, 1'b0), 11);
        expect_key(8'h75, 1'b1, 1'b1);
        send_bits(frame(8'h75, 1'b0), 11);
        expect_key(8'h1C, 1'b0, 1'b0);
        send_bits(frame(8'h1C, 1'b0), 11);

        // Repeated prefixes stay set.
        send_bits(frame(8'hE0, 1'b0), 11);
        send_bits(frame(8'hE0, 1'b0), 11);
        expect_key(8'h6B, 1'b1, 1'b0);
        send_bits(frame(8'h6B, 1'b0), 11);

        // Bad parity: error pulse, key register keeps the last delivered code.
        expect_err(LAT);
        send_bits(frame(8'h1C, 1'b1), 11);
        check("key_hold_after_parity_err", 32'(kbd_key), 32'h6B);
        check("ext_hold_after_parity_err", 32'(kbd_extended), 32'd1);

        // Pending E0 then a stalled frame: timeout clears the prefix.
        send_bits(frame(8'hE0, 1'b0), 11);
        expect_err(LAT + TIMEOUT_CYC);
        send_bits(frame(8'h3A, 1'b0), 5);
        repeat (TIMEOUT_CYC + 50) @(negedge clk);
        expect_key(8'h29, 1'b0, 1'b0);
        send_bits(frame(8'h29, 1'b0), 11);

        // Short kbd_clk glitches before the start bit and mid-frame must be ignored.
        glitch_mask = 11'b000_0001_0001;
        expect_key(8'h33, 1'b0, 1'b0);
        send_bits(frame(8'h33, 1'b0), 11);
        glitch_mask = '0;

        // Pending E0, then reset one cycle after the 4th bit of a frame.
        send_bits(frame(8'hE0, 1'b0), 11);
        send_bits(frame(8'h5A, 1'b0), 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_outputs_reset("midframe_reset");
        repeat (20) @(negedge clk);
        expect_key(8'h5A, 1'b0, 1'b0);
        send_bits(frame(8'h5A, 1'b0), 11);

        for (int w = 0; w < 2000 && sb.size() > 0; w++) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (50) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive clk cycles a synchronized PS/2 line must hold a new level before the filtered level changes.
REQ-002 Parameter TIMEOUT_CYC, default 48000: clk cycles (1 ms at 48 MHz) allowed between filtered falling edges inside a frame.
REQ-003 clk  input  1  system clock (48 MHz); all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 kbd_clk  input  1  raw PS/2 keyboard clock line, asynchronous.
REQ-006 kbd_data  input  1  raw PS/2 keyboard data line, asynchronous.
REQ-007 kbd_key  output  8  last delivered scancode byte, prefixes stripped.
REQ-008 kbd_key_valid  output  1  one-cycle strobe: kbd_key, kbd_extended and kbd_released are new.
REQ-009 kbd_extended  output  1  delivered code was preceded by 0xE0 in the same sequence.
REQ-010 kbd_released  output  1  delivered code was preceded by 0xF0 in the same sequence.
REQ-011 frame_err  output  1  one-cycle strobe: parity error, stop-bit error or timeout.

Function
REQ-012 Each line passes through a 2-flop synchronizer, then a filter; the filtered level changes only after FILTER_LEN consecutive cycles at the opposite level, and any mismatch restarts the count.
REQ-013 A sample event is the cycle in which filtered kbd_clk goes 1->0; filtered kbd_data is sampled in that same cycle.
REQ-014 FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: sample event with data=0 -> DATA, bit counter=0; a sample event with data=1 is ignored and the FSM stays in IDLE.
REQ-016 DATA: 8 sample events shift bits LSB first; on the 8th -> PARITY.
REQ-017 PARITY: sample event checks odd parity over the 8 data bits plus the parity bit -> STOP, with the result latched.
REQ-018 STOP: sample event -> IDLE; if stop=1 and parity is OK the byte is accepted, otherwise frame_err pulses.
REQ-019 Timeout counter clears on every sample event and in IDLE; when it reaches TIMEOUT_CYC in any non-IDLE state, FSM -> IDLE and frame_err pulses for 1 cycle.
REQ-020 Accepted 0xE0: set ext_pend, no strobe. Accepted 0xF0: set rel_pend, no strobe.
REQ-021 Any other accepted byte (0xE1, 0xAA, 0xFA, 0xEE included) is delivered with kbd_extended=ext_pend and kbd_released=rel_pend, after which both pending flags clear.
REQ-022 Latency: kbd_key_valid asserts in the cycle after the STOP sample event, for exactly 1 cycle.
REQ-023 kbd_key, kbd_extended and kbd_released are registered and hold their values until the next strobe.
REQ-024 On any frame_err, the byte is discarded and ext_pend and rel_pend clear.
REQ-025 kbd_key_valid and frame_err are never asserted in the same cycle.
REQ-026 A sample event that coincides with the timeout cycle is lost; the timeout takes priority.
REQ-027 Repeated prefixes (E0 E0 or F0 F0) stay set, without toggling.

Reset
REQ-028 While rst=1 at a clk edge: FSM=IDLE, bit counter, timeout counter and filter counters=0, synchronizers and filtered levels=1, ext_pend and rel_pend=0.
REQ-029 Reset values of outputs: kbd_key=0x00, kbd_key_valid=0, kbd_extended=0, kbd_released=0, frame_err=0.
REQ-030 Reset asserted mid-frame abandons the frame silently, with no frame_err and no strobe.

Structure
REQ-031 Package ps2_pkg holds the FSM state enumeration and the constants PS2_PFX_EXT=0xE0 and PS2_PFX_REL=0xF0.
REQ-032 Sub-module ps2_line_filter (synchronizer plus FILTER_LEN filter, reset level 1) is instantiated once per line.
REQ-033 Frame FSM and prefix decoder reside in ps2_kbd_rx; target size is 120-400 RTL lines total.

Verification
REQ-034 Frame 0x1C with parity=0 and stop=1, 30 us bit period -> one strobe, kbd_key=0x1C, ext=0, rel=0, one cycle after the 11th falling edge.
REQ-035 Frames F0, 1C -> single strobe with key=0x1C and rel=1; frames E0, F0, 75 -> key=0x75 with ext=1 and rel=1; the next frame 0x1C delivers with ext=0 and rel=0.
REQ-036 Frame 0x1C with parity bit=1 -> frame_err pulse, no strobe, kbd_key keeps its previous value.
REQ-037 Send 5 bits then stop clocking -> frame_err exactly TIMEOUT_CYC cycles after the 5th edge; the next good frame 0x29 delivers correctly.
REQ-038 3-cycle low glitch on kbd_clk with FILTER_LEN=8 -> no sample event and no state change.
REQ-039 Assert rst for 1 cycle after the 4th bit of a frame -> all outputs 0, no frame_err; the following full frame 0x5A delivers key=0x5A.
